// File: rtl/alu_arbiter.sv
// Two-client arbiter in front of a single 16-bit ALU.
// One operation in flight; result held until its owner takes it.
module alu_arbiter #(
  parameter int DATA_W     = 16,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q;
  logic              owner_q;
  logic              last_q;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_y;
  logic              gnt0;
  logic              gnt1;
  logic              idle;
  logic              accept;
  logic              rsp_take;
  logic [4:0]        shamt;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | PRIO_FIXED | last_q);
    gnt1 = req1_valid & ~gnt0;
  end

  assign idle       = (state_q == IDLE);
  assign req0_ready = idle & gnt0 & ~reset;
  assign req1_ready = idle & gnt1 & ~reset;
  assign accept     = (req0_valid & req0_ready) |
                      (req1_valid & req1_ready);
  assign rsp_take   = owner_q ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign busy       = ~idle;

  assign shamt = b_q[4:0];

  always_comb begin
    alu_y = '0;
    unique case (sel_q)
      3'd0: alu_y = a_q + b_q;
      3'd1: alu_y = a_q - b_q;
      3'd2: alu_y = a_q & b_q;
      3'd3: alu_y = a_q | b_q;
      3'd4: alu_y = a_q ^ b_q;
      3'd5: alu_y = shamt[4] ? '0 : a_q << shamt[3:0];
      3'd6: alu_y = shamt[4] ? '0 : a_q >> shamt[3:0];
      3'd7: begin
        if (a_q == b_q)     alu_y = '0;
        else if (a_q > b_q) alu_y = DATA_W'(1);
        else                alu_y = DATA_W'(2);
      end
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      sel_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXEC;
            owner_q <= gnt1;
            sel_q   <= gnt1 ? req1_sel : req0_sel;
            a_q     <= gnt1 ? req1_a : req0_a;
            b_q     <= gnt1 ? req1_b : req0_b;
          end
        end
        EXEC: begin
          result_q <= alu_y;
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            state_q <= IDLE;
            last_q  <= owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
